// File: rtl/snn_seq_ctrl.sv
// Sequencer for a spiking-network classifier: unpacks received image bytes into a 784x1
// input RAM, starts the core, latches its digit and transmits it as an ASCII character.
module snn_seq_ctrl #(
  parameter int unsigned NUM_BYTES  = 98,
  parameter logic [7:0]  ASCII_BASE = 8'h30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  input  logic [9:0] core_addr,
  output logic [9:0] ram_addr,
  output logic       ram_we,
  output logic       ram_wdata,
  output logic       core_start,
  input  logic       core_done,
  input  logic [3:0] core_digit,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic [3:0] result,
  output logic       busy,
  output logic       overrun
);

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned CNT_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(7);

  typedef enum logic [2:0] {
    LOAD_WAIT = 3'd0,
    SHIFT     = 3'd1,
    START     = 3'd2,
    RUN       = 3'd3,
    TX_WAIT   = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_byte_cnt;
  logic [BIT_W-1:0]   r_bit_k;
  logic [7:0]         r_shift;
  logic [3:0]         r_result;
  logic [7:0]         r_tx_data;
  logic               r_tx_start;
  logic               r_overrun;
  logic [ADDR_W-1:0]  w_shift_addr;
  logic [7:0]         w_tx_char;
  logic               w_last_bit;
  logic               w_last_byte;

  assign w_last_bit   = (r_bit_k == LAST_BIT);
  assign w_last_byte  = (r_byte_cnt == LAST_BYTE);
  assign w_shift_addr = ADDR_W'((ADDR_W'(r_byte_cnt) << 3) | ADDR_W'(r_bit_k));
  // Digits above 9 have no ASCII numeral, so they are reported as '?'.
  assign w_tx_char    = (r_result > 4'd9) ? 8'h3F : 8'(ASCII_BASE + {4'h0, r_result});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LOAD_WAIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LOAD_WAIT: if (rx_rdy) w_state_nxt = SHIFT;
      SHIFT: begin
        if (w_last_bit) begin
          w_state_nxt = w_last_byte ? START : LOAD_WAIT;
        end
      end
      START:     w_state_nxt = RUN;
      RUN:       if (core_done) w_state_nxt = TX_WAIT;
      TX_WAIT:   if (!tx_busy) w_state_nxt = LOAD_WAIT;
      default:   w_state_nxt = LOAD_WAIT;
    endcase
  end

  // RAM port belongs to the core except while a byte is being unpacked.
  always_comb begin
    ram_addr   = core_addr;
    ram_we     = 1'b0;
    ram_wdata  = 1'b0;
    core_start = 1'b0;
    busy       = 1'b1;
    case (r_state)
      LOAD_WAIT: busy = 1'b0;
      SHIFT: begin
        ram_addr  = w_shift_addr;
        ram_we    = 1'b1;
        ram_wdata = r_shift[r_bit_k];
      end
      START:     core_start = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_cnt <= '0;
      r_bit_k    <= '0;
      r_shift    <= '0;
      r_result   <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      if (rx_rdy) begin
        if (r_state == LOAD_WAIT) begin
          r_shift <= rx_data;
          r_bit_k <= '0;
          if (r_byte_cnt == '0) r_overrun <= 1'b0;
        end else begin
          r_overrun <= 1'b1;
        end
      end
      if (r_state == SHIFT) begin
        r_bit_k <= r_bit_k + BIT_W'(1);
        if (w_last_bit) begin
          r_byte_cnt <= w_last_byte ? '0 : r_byte_cnt + CNT_W'(1);
        end
      end
      if ((r_state == RUN) && core_done) begin
        r_result <= core_digit;
      end
      if ((r_state == TX_WAIT) && !tx_busy) begin
        r_tx_start <= 1'b1;
        r_tx_data  <= w_tx_char;
      end
    end
  end

  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign result   = r_result;
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_snn_seq_ctrl.sv
// Directed bench for snn_seq_ctrl: frame loading, core handshake, transmit pacing,
// overrun handling and asynchronous reset mid-frame.
module tb_snn_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic [9:0] core_addr;
  logic [9:0] ram_addr;
  logic       ram_we;
  logic       ram_wdata;
  logic       core_start;
  logic       core_done;
  logic [3:0] core_digit;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic [3:0] result;
  logic       busy;
  logic       overrun;

  int n_tests;
  int n_fail;
  int exp_cnt;

  snn_seq_ctrl #(.NUM_BYTES(98), .ASCII_BASE(8'h30)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .core_addr  (core_addr),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .core_start (core_start),
    .core_done  (core_done),
    .core_digit (core_digit),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .result     (result),
    .busy       (busy),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One byte: strobe, then 8 write cycles at exp_cnt*8+k; optional stray rx_rdy at step drop_at.
  task automatic send_byte(input logic [7:0] b, input int drop_at);
    logic [31:0] base;
    base = 32'(exp_cnt * 8);
    rx_data = b;
    rx_rdy  = 1'b1;
    tick();
    rx_rdy  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("shift_we", 32'(ram_we), 32'd1);
      chk("shift_addr", 32'(ram_addr), base + 32'(k));
      chk("shift_wdata", 32'(ram_wdata), 32'(b[k]));
      if (k == drop_at) rx_rdy = 1'b1;
      tick();
      rx_rdy = 1'b0;
    end
    exp_cnt = (exp_cnt == 97) ? 0 : exp_cnt + 1;
    chk("post_shift_we", 32'(ram_we), 32'd0);
  endtask

  task automatic send_frame(input int fid, input logic [7:0] first, input int drop_byte,
                            input int nbytes);
    logic [7:0] b;
    for (int i = 0; i < nbytes; i++) begin
      b = (i == 0) ? first : 8'(i * 29 + fid * 7 + 3);
      send_byte(b, (i == drop_byte) ? 3 : -1);
      if (i == 0) chk("ov_after_byte0", 32'(overrun), (drop_byte == 0) ? 32'd1 : 32'd0);
      if (i == drop_byte) chk("ov_set_shift", 32'(overrun), 32'd1);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_cnt = 0;
    rst        = 1'b1;
    rx_rdy     = 1'b0;
    rx_data    = 8'h00;
    core_addr  = 10'h155;
    core_done  = 1'b0;
    core_digit = 4'h0;
    tx_busy    = 1'b0;
    #1;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h155);
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    tick();

    // Frame 1: byte 0 = A5, clean load, digit 7 -> '7'
    send_frame(1, 8'hA5, -1, 98);
    chk("f1_core_start", 32'(core_start), 32'd1);
    chk("f1_busy_start", 32'(busy), 32'd1);
    tick();
    chk("f1_start_pulse_end", 32'(core_start), 32'd0);
    chk("f1_busy_run", 32'(busy), 32'd1);
    tick();
    tick();
    chk("f1_no_tx_in_run", 32'(tx_start), 32'd0);
    core_digit = 4'd7;
    core_done  = 1'b1;
    tick();
    core_done  = 1'b0;
    chk("f1_result", 32'(result), 32'd7);
    chk("f1_tx_not_yet", 32'(tx_start), 32'd0);
    tick();
    chk("f1_tx_start", 32'(tx_start), 32'd1);
    chk("f1_tx_data", 32'(tx_data), 32'h37);
    chk("f1_idle_busy", 32'(busy), 32'd0);
    tick();
    chk("f1_tx_pulse_end", 32'(tx_start), 32'd0);
    chk("f1_tx_data_hold", 32'(tx_data), 32'h37);
    chk("f1_overrun_clean", 32'(overrun), 32'd0);

    // Stray core_done while idle leaves result alone
    core_digit = 4'd9;
    core_done  = 1'b1;
    tick();
    core_done  = 1'b0;
    tick();
    chk("idle_done_result", 32'(result), 32'd7);
    chk("idle_done_busy", 32'(busy), 32'd0);

    // Frame 2: stray rx during byte 5, digit C with tx_busy held 50 cycles
    core_addr = 10'h2AB;
    send_frame(2, 8'h5A, 5, 98);
    chk("f2_core_start", 32'(core_start), 32'd1);
    tick();
    chk("f2_run_ram_addr", 32'(ram_addr), 32'h2AB);
    tx_busy    = 1'b1;
    core_digit = 4'hC;
    core_done  = 1'b1;
    tick();
    core_done  = 1'b0;
    chk("f2_result", 32'(result), 32'hC);
    for (int i = 0; i < 50; i++) begin
      chk("f2_tx_withheld", 32'(tx_start), 32'd0);
      tick();
    end
    chk("f2_busy_tx_wait", 32'(busy), 32'd1);
    tx_busy = 1'b0;
    tick();
    chk("f2_tx_start", 32'(tx_start), 32'd1);
    chk("f2_tx_data_q", 32'(tx_data), 32'h3F);
    tick();
    chk("f2_overrun_sticky", 32'(overrun), 32'd1);

    // Frame 3: byte 0 clears overrun, drop at byte 20, reset during byte 40
    core_addr = 10'h000;
    send_frame(3, 8'h11, 20, 40);
    rx_data = 8'hFF;
    rx_rdy  = 1'b1;
    tick();
    rx_rdy  = 1'b0;
    chk("f3_b40_addr0", 32'(ram_addr), 32'd320);
    tick();
    chk("f3_b40_addr1", 32'(ram_addr), 32'd321);
    rst = 1'b1;
    #1;
    chk("mid_rst_ram_we", 32'(ram_we), 32'd0);
    chk("mid_rst_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("mid_rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_core_start", 32'(core_start), 32'd0);
    chk("mid_rst_tx_start", 32'(tx_start), 32'd0);
    chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
    chk("mid_rst_result", 32'(result), 32'd0);
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    tick();

    // Frame 4: reload from byte 0, then rx_rdy coincident with core_done in RUN
    send_frame(4, 8'h3C, -1, 98);
    chk("f4_core_start", 32'(core_start), 32'd1);
    tick();
    tick();
    core_digit = 4'd2;
    core_done  = 1'b1;
    rx_data    = 8'hEE;
    rx_rdy     = 1'b1;
    tick();
    core_done  = 1'b0;
    rx_rdy     = 1'b0;
    chk("f4_result", 32'(result), 32'd2);
    chk("f4_overrun_run", 32'(overrun), 32'd1);
    tick();
    chk("f4_tx_start", 32'(tx_start), 32'd1);
    chk("f4_tx_data", 32'(tx_data), 32'h32);
    chk("f4_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
